// File: rtl/ps2_key_ctrl.sv
// PS/2 key-state controller: turns scan-code bytes into per-player held-key
// levels and rate-limited single-cycle fire pulses.
// Optional feature macro: KEYCTL_EXT_ARROWS_EN (player 1 moves on the
// extended arrow keys instead of I/K/J/L).
module ps2_key_ctrl #(
  parameter int unsigned TIMEOUT_CYC   = 2_000_000,
  parameter int unsigned FIRE_COOLDOWN = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       up1,
  output logic       down1,
  output logic       left1,
  output logic       right1,
  output logic       up2,
  output logic       down2,
  output logic       left2,
  output logic       right2,
  output logic       fire1,
  output logic       fire2
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CD_W  = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [7:0] K_BRK = 8'hF0;
  localparam logic [7:0] K_EXT = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  // movement levels packed as {up, down, left, right}
  logic [3:0]        mv1_q, mv1_d;
  logic [3:0]        mv2_q, mv2_d;
  // fire-key held bits and pulses, index 0 = player 1, index 1 = player 2
  logic [1:0]        held_q, held_d;
  logic [1:0]        fire_q, fire_d;
  logic [CD_W-1:0]   cd1_q, cd1_d;
  logic [CD_W-1:0]   cd2_q, cd2_d;

  logic              code_vld;
  logic              code_ext;
  logic              code_brk;

  // Prefix FSM with timeout; flags a completed code for the key decoder
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    code_vld = 1'b0;
    code_ext = 1'b0;
    code_brk = 1'b0;
    if (rx_err) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else if (rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == K_BRK)      state_d = S_BRK;
          else if (rx_data == K_EXT) state_d = S_EXT;
          else                       code_vld = 1'b1;
        end
        S_BRK: begin
          state_d  = S_IDLE;
          code_vld = 1'b1;
          code_brk = 1'b1;
        end
        S_EXT: begin
          if (rx_data == K_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d  = S_IDLE;
            code_vld = 1'b1;
            code_ext = 1'b1;
          end
        end
        S_EXT_BRK: begin
          state_d  = S_IDLE;
          code_vld = 1'b1;
          code_ext = 1'b1;
          code_brk = 1'b1;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // an incoming byte on the expiry cycle takes priority (handled above)
      if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = TMO_W'(tmo_q + 1'b1);
      end
    end
  end

  // Key decode: movement levels, fire held bits, cooldowns and pulses
  always_comb begin
    mv1_d  = mv1_q;
    mv2_d  = mv2_q;
    held_d = held_q;
    fire_d = '0;
    cd1_d  = (cd1_q != '0) ? CD_W'(cd1_q - 1'b1) : cd1_q;
    cd2_d  = (cd2_q != '0) ? CD_W'(cd2_q - 1'b1) : cd2_q;
    if (code_vld && !code_ext) begin
      case (rx_data)
        8'h1D: mv2_d[3] = !code_brk;
        8'h1B: mv2_d[2] = !code_brk;
        8'h1C: mv2_d[1] = !code_brk;
        8'h23: mv2_d[0] = !code_brk;
`ifndef KEYCTL_EXT_ARROWS_EN
        8'h43: mv1_d[3] = !code_brk;
        8'h42: mv1_d[2] = !code_brk;
        8'h3B: mv1_d[1] = !code_brk;
        8'h4B: mv1_d[0] = !code_brk;
`endif
        8'h5A: begin
          if (code_brk) begin
            held_d[0] = 1'b0;
          end else if (!held_q[0]) begin
            held_d[0] = 1'b1;
            if (cd1_q == '0) begin
              fire_d[0] = 1'b1;
              cd1_d     = CD_W'(FIRE_COOLDOWN);
            end
          end
        end
        8'h29: begin
          if (code_brk) begin
            held_d[1] = 1'b0;
          end else if (!held_q[1]) begin
            held_d[1] = 1'b1;
            if (cd2_q == '0) begin
              fire_d[1] = 1'b1;
              cd2_d     = CD_W'(FIRE_COOLDOWN);
            end
          end
        end
        default: ;
      endcase
    end
`ifdef KEYCTL_EXT_ARROWS_EN
    if (code_vld && code_ext) begin
      case (rx_data)
        8'h75:   mv1_d[3] = !code_brk;
        8'h72:   mv1_d[2] = !code_brk;
        8'h6B:   mv1_d[1] = !code_brk;
        8'h74:   mv1_d[0] = !code_brk;
        default: ;
      endcase
    end
`endif
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      mv1_q   <= '0;
      mv2_q   <= '0;
      held_q  <= '0;
      fire_q  <= '0;
      cd1_q   <= '0;
      cd2_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      mv1_q   <= mv1_d;
      mv2_q   <= mv2_d;
      held_q  <= held_d;
      fire_q  <= fire_d;
      cd1_q   <= cd1_d;
      cd2_q   <= cd2_d;
    end
  end

  assign up1    = mv1_q[3];
  assign down1  = mv1_q[2];
  assign left1  = mv1_q[1];
  assign right1 = mv1_q[0];
  assign up2    = mv2_q[3];
  assign down2  = mv2_q[2];
  assign left2  = mv2_q[1];
  assign right2 = mv2_q[0];
  assign fire1  = fire_q[0];
  assign fire2  = fire_q[1];

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: each driven cycle pushes the expected
// output vector; a monitor pops and compares one entry after every clock edge.
module tb_ps2_key_ctrl;

  localparam int unsigned TIMEOUT_CYC   = 100;
  localparam int unsigned FIRE_COOLDOWN = 50;

  // output vector bit positions
  localparam int UP1 = 9, DN1 = 8, LF1 = 7, RT1 = 6;
  localparam int UP2 = 5, DN2 = 4, LF2 = 3, RT2 = 2;
  localparam logic [9:0] M_F1 = 10'b00_0000_0010;
  localparam logic [9:0] M_F2 = 10'b00_0000_0001;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       up1, down1, left1, right1;
  logic       up2, down2, left2, right2;
  logic       fire1, fire2;
  logic [9:0] outs;

  int         n_chk;
  int         n_fail;
  logic [9:0] sb_exp[$];
  string      sb_tag[$];
  logic [9:0] lv;

  ps2_key_ctrl #(
    .TIMEOUT_CYC   (TIMEOUT_CYC),
    .FIRE_COOLDOWN (FIRE_COOLDOWN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .up1      (up1),
    .down1    (down1),
    .left1    (left1),
    .right1   (right1),
    .up2      (up2),
    .down2    (down2),
    .left2    (left2),
    .right2   (right2),
    .fire1    (fire1),
    .fire2    (fire2)
  );

  assign outs = {up1, down1, left1, right1, up2, down2, left2, right2, fire1, fire2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // scoreboard monitor: compare DUT outputs just after each active edge
  always @(posedge clk) begin
    #1;
    if (sb_exp.size() != 0) begin
      chk(sb_tag.pop_front(), outs, sb_exp.pop_front());
    end
  end

  task automatic step(input string tag, input logic v, input logic e,
                      input logic [7:0] d, input logic [9:0] ex);
    rx_valid = v;
    rx_err   = e;
    rx_data  = d;
    sb_exp.push_back(ex);
    sb_tag.push_back(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic [9:0] ex);
    step(tag, 1'b1, 1'b0, d, ex);
  endtask

  task automatic idle(input string tag, input int n, input logic [9:0] ex);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 8'h00, ex);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    lv       = '0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rx_data  = 8'h00;

    // reset state
    idle("reset", 2, 10'd0);
    reset = 1'b0;
    idle("post_reset", 2, 10'd0);

    // W make / break
    lv[UP2] = 1'b1; send("w_make", 8'h1D, lv);
    send("w_f0", 8'hF0, lv);
    lv[UP2] = 1'b0; send("w_break", 8'h1D, lv);
    idle("w_idle", 2, lv);

    // all player-2 directions including opposing pairs, plus unmapped code
    lv[DN2] = 1'b1; send("s_make", 8'h1B, lv);
    lv[LF2] = 1'b1; send("a_make", 8'h1C, lv);
    lv[RT2] = 1'b1; send("d_make", 8'h23, lv);
    lv[UP2] = 1'b1; send("w_make2", 8'h1D, lv);
    send("unmapped", 8'h15, lv);
    send("f0", 8'hF0, lv); lv[DN2] = 1'b0; send("s_break", 8'h1B, lv);
    send("f0", 8'hF0, lv); lv[LF2] = 1'b0; send("a_break", 8'h1C, lv);
    send("f0", 8'hF0, lv); lv[RT2] = 1'b0; send("d_break", 8'h23, lv);
    send("f0", 8'hF0, lv); lv[UP2] = 1'b0; send("w_break2", 8'h1D, lv);

    // fire2: pulse, typematic repeat, cooldown block, cooldown boundary (k = cycle offset)
    send("fire2_first", 8'h29, lv | M_F2);             // k=0
    idle("fire2_gap", 4, lv);                           // k=1..4
    send("fire2_repeat", 8'h29, lv);                    // k=5
    send("f0", 8'hF0, lv);                              // k=6
    send("fire2_break", 8'h29, lv);                     // k=7
    idle("fire2_wait", 12, lv);                         // k=8..19
    send("fire2_cooldown", 8'h29, lv);                  // k=20
    send("f0", 8'hF0, lv);                              // k=21
    send("fire2_break2", 8'h29, lv);                    // k=22
    idle("fire2_wait2", 28, lv);                        // k=23..50
    send("fire2_cd_zero", 8'h29, lv | M_F2);            // k=51
    send("f0", 8'hF0, lv);
    send("fire2_break3", 8'h29, lv);
    idle("cd_expire", 55, lv);

    // back-to-back fire codes of both players
    send("b2b_fire2", 8'h29, lv | M_F2);
    send("b2b_fire1", 8'h5A, lv | M_F1);
    idle("b2b_after", 1, lv);
    send("f0", 8'hF0, lv); send("fire2_rel", 8'h29, lv);
    send("f0", 8'hF0, lv); send("fire1_rel", 8'h5A, lv);

    // player-1 movement
`ifdef KEYCTL_EXT_ARROWS_EN
    send("e0", 8'hE0, lv); lv[UP1] = 1'b1; send("ext_up_make", 8'h75, lv);
    send("e0", 8'hE0, lv); send("e0_f0", 8'hF0, lv);
    lv[UP1] = 1'b0; send("ext_up_break", 8'h75, lv);
    send("e0", 8'hE0, lv); lv[LF1] = 1'b1; send("ext_left_make", 8'h6B, lv);
    send("e0", 8'hE0, lv); send("e0_f0", 8'hF0, lv);
    lv[LF1] = 1'b0; send("ext_left_break", 8'h6B, lv);
    send("i_unmapped", 8'h43, lv);
`else
    send("e0", 8'hE0, lv); send("ext_up_ignored", 8'h75, lv);
    send("e0", 8'hE0, lv); send("e0_f0", 8'hF0, lv); send("ext_brk_ignored", 8'h75, lv);
    send("e0", 8'hE0, lv); send("ext_w_ignored", 8'h1D, lv);
    lv[UP1] = 1'b1; send("i_make", 8'h43, lv);
    lv[DN1] = 1'b1; send("k_make", 8'h42, lv);
    lv[LF1] = 1'b1; send("j_make", 8'h3B, lv);
    lv[RT1] = 1'b1; send("l_make", 8'h4B, lv);
    send("f0", 8'hF0, lv); lv[UP1] = 1'b0; send("i_break", 8'h43, lv);
    send("f0", 8'hF0, lv); lv[DN1] = 1'b0; send("k_break", 8'h42, lv);
    send("f0", 8'hF0, lv); lv[LF1] = 1'b0; send("j_break", 8'h3B, lv);
    send("f0", 8'hF0, lv); lv[RT1] = 1'b0; send("l_break", 8'h4B, lv);
`endif

    // prefix timeout: 101 idle cycles expires, 100 does not
    send("f0", 8'hF0, lv);
    idle("tmo_wait", 101, lv);
    lv[LF2] = 1'b1; send("tmo_make", 8'h1C, lv);
    send("f0", 8'hF0, lv);
    idle("tmo_edge_wait", 100, lv);
    lv[LF2] = 1'b0; send("tmo_edge_break", 8'h1C, lv);

    // rx_err aborts prefix (and wins over rx_valid)
    send("f0", 8'hF0, lv);
    step("err_byte", 1'b1, 1'b1, 8'h1C, lv);
    lv[LF2] = 1'b1; send("err_then_make", 8'h1C, lv);
    send("f0", 8'hF0, lv);
    step("err_keeps_held", 1'b1, 1'b1, 8'h1C, lv);
    send("err_make_again", 8'h1C, lv);
    send("f0", 8'hF0, lv); lv[LF2] = 1'b0; send("err_release", 8'h1C, lv);

    // reset in the middle of a break prefix
    lv[UP2] = 1'b1; send("rst_w_make", 8'h1D, lv);
    send("rst_f0", 8'hF0, lv);
    reset = 1'b1;
    lv = '0;
    idle("mid_reset", 1, lv);
    reset = 1'b0;
    lv[UP2] = 1'b1; send("rst_idle_make", 8'h1D, lv);
    send("rst_fire2", 8'h29, lv | M_F2);
    idle("tail", 2, lv);

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_exp.size() != 0; i++) @(negedge clk);
    chk("drain", 10'(sb_exp.size()), 10'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

PS/2 key-state controller sitting between the PS/2 byte receiver and the tank/bullet logic in `tankWar_top`. It consumes received scan-code bytes and tracks make, break (`F0`) and extended (`E0`) prefixes. It maintains held-key levels for both players' movement controls and issues rate-limited single-cycle fire pulses. It is the only block that interprets keyboard codes; tanks see only clean per-player control bits.

## Interface
Parameters:
- `TIMEOUT_CYC`, 2_000_000: cycles a prefix state waits for the next byte before aborting to IDLE (20 ms at 100 MHz).
- `FIRE_COOLDOWN`, 25_000_000: minimum cycles between two fire pulses of one player (250 ms).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received scan-code byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid.
- `rx_err`  in  1  one-cycle strobe; parity/framing error on the current frame.
- `up1`, `down1`, `left1`, `right1`  out  1 each  player-1 held-key levels.
- `up2`, `down2`, `left2`, `right2`  out  1 each  player-2 held-key levels.
- `fire1`, `fire2`  out  1 each  single-cycle fire pulses.

## Operation
- Player-2 keys: W=`1D`, S=`1B`, A=`1C`, D=`23`, fire Space=`29`.
- Player-1 keys: set by `KEYCTL_EXT_ARROWS_EN`. Fire is always Enter=`5A`, non-extended.
- The FSM has four states: IDLE, BRK, EXT and EXT_BRK.
- In IDLE:
  - `F0` goes to BRK.
  - `E0` goes to EXT.
  - Any other byte is a non-extended make code and stays in IDLE.
- In BRK, any byte is a non-extended break code; go to IDLE.
- In EXT:
  - `F0` goes to EXT_BRK.
  - Any other byte is an extended make code; go to IDLE.
- In EXT_BRK, any byte is an extended break code; go to IDLE.
- A make of a mapped movement key sets its held bit. A break clears it. Unmapped codes change no output.
- Opposing directions may both be held. Both outputs are then 1; this block does no resolution.
- Fire key:
  - Each player has an internal held bit and a down-counter `cd` (width `$clog2(FIRE_COOLDOWN+1)`).
  - On a make with held bit = 0 and `cd` = 0: pulse fire, set held, load `cd` = `FIRE_COOLDOWN`.
  - On a make with held bit = 1 (typematic repeat): no pulse.
  - On a make with held bit = 0 and `cd` ≠ 0: set held, no pulse, and no pulse is queued.
  - On a break: clear held.
  - `cd` decrements every cycle while nonzero and saturates at 0.
- `rx_err` in any state: the byte is discarded, the FSM goes to IDLE, and held bits are unchanged.
- If `rx_err` and `rx_valid` arrive in the same cycle, `rx_err` wins.
- Prefix timeout: in BRK, EXT or EXT_BRK, a counter runs from entry. After `TIMEOUT_CYC` cycles with no `rx_valid`, the FSM returns to IDLE and no held bit changes.

## Timing
- Reset: all outputs 0, held bits 0, `cd` = 0, FSM in IDLE, timeout counter 0.
- Reset mid-sequence aborts any partial code.
- All outputs are registered. For an `rx_valid` byte that completes a code in cycle N, levels and the fire pulse change at cycle N+1.
- `fire1` and `fire2` are high for exactly one cycle. The two players are fully independent; both may pulse in the same cycle.
- Cooldown boundary: `cd` reaching 0 in the same cycle as a new fire make allows the pulse. The check uses the registered `cd` value, and the decrement applies to the next value.
- Timeout boundary: if `rx_valid` arrives in the cycle the counter reaches `TIMEOUT_CYC`, the byte is processed normally and the timeout is ignored.
- Back-to-back `rx_valid` on consecutive cycles must be handled with no lost byte.

## Configuration
- `KEYCTL_EXT_ARROWS_EN` defined: player-1 movement uses the extended arrow keys `E0 75` up, `E0 72` down, `E0 6B` left, `E0 74` right.
- `KEYCTL_EXT_ARROWS_EN` undefined: player-1 movement uses I=`43` up, K=`42` down, J=`3B` left, L=`4B` right.
- Undefined also means all extended make/break codes are ignored. The `E0` prefix is still consumed and the FSM still walks EXT and EXT_BRK.

## Test plan
Use `TIMEOUT_CYC`=100 and `FIRE_COOLDOWN`=50.
- Reset, then bytes `1D`; then `F0`,`1D` → `up2`=1 one cycle after the `1D` make. `up2`=0 one cycle after the break `1D`. No other output toggles.
- `29`, then `29` 5 cycles later, then `F0`,`29` → exactly one `fire2` pulse. After the break, `29` sent 60 cycles after the first pulse → second pulse. The same `29` sent 20 cycles after the first pulse → no pulse.
- `29` and `5A` in consecutive cycles → `fire2` and `fire1` each pulse once in consecutive cycles.
- With `KEYCTL_EXT_ARROWS_EN`: `E0`,`75` → `up1`=1; `E0`,`F0`,`75` → `up1`=0. Without it, the same bytes leave `up1`=0, and `43` → `up1`=1.
- `F0` then 101 idle cycles, then `1C` → `left2`=1, because the byte is treated as a make after timeout.
- `F0` with `rx_err` on the next byte, then `1C` → `left2`=1.
- `1D` held, then `reset` pulse mid-`F0` prefix → `up2`=0 and the FSM is in IDLE after reset.
